mc_control_unit: RTL and testbench

//   Multi-cycle control FSM for the 16-bit load_store processor. It sequences the shared

---
 rtl/mc_control_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multi-cycle control FSM for the 16-bit load/store processor.
//            Steps the shared datapath through fetch, decode, execute, memory
//            and writeback. Inputs are IR[15:12], the ALU zero flag and the
//            memory-ready handshake. Also counts retired instructions.
// Ports    : clock, rst                      - clock, synchronous active-high reset
//            opcode, zero, mem_ready         - IR opcode, ALU zero, memory done
//            pc_write, pc_src, ir_write      - PC / IR load controls
//            iord, mem_read, mem_write       - memory port controls
//            alu_src_a, alu_src_b, alu_op    - ALU operand / operation select
//            reg_write, wb_sel, out_write    - writeback and output-port controls
//            halted, illegal, retired        - status and retired count
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_unit #(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             out_write,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // State encoding
    localparam logic [3:0] c_S_FETCH    = 4'd0;
    localparam logic [3:0] c_S_DECODE   = 4'd1;
    localparam logic [3:0] c_S_EXEC_R   = 4'd2;
    localparam logic [3:0] c_S_EXEC_I   = 4'd3;
    localparam logic [3:0] c_S_MEM_ADDR = 4'd4;
    localparam logic [3:0] c_S_MEM_RD   = 4'd5;
    localparam logic [3:0] c_S_MEM_WB   = 4'd6;
    localparam logic [3:0] c_S_MEM_WR   = 4'd7;
    localparam logic [3:0] c_S_BRANCH   = 4'd8;
    localparam logic [3:0] c_S_JUMP     = 4'd9;
    localparam logic [3:0] c_S_ALU_WB   = 4'd10;
    localparam logic [3:0] c_S_IO_IN    = 4'd11;
    localparam logic [3:0] c_S_IO_OUT   = 4'd12;
    localparam logic [3:0] c_S_HALT     = 4'd13;

    // Opcodes
    localparam logic [3:0] c_OP_ADDI = 4'h4;
    localparam logic [3:0] c_OP_LW   = 4'h5;
    localparam logic [3:0] c_OP_SW   = 4'h6;
    localparam logic [3:0] c_OP_BEQ  = 4'h7;
    localparam logic [3:0] c_OP_BNE  = 4'h8;
    localparam logic [3:0] c_OP_JAL  = 4'h9;
    localparam logic [3:0] c_OP_IN   = 4'hA;
    localparam logic [3:0] c_OP_OUT  = 4'hB;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    // ALU / mux select codes
    localparam logic [1:0] c_ALU_ADD   = 2'd0;
    localparam logic [1:0] c_ALU_SUB   = 2'd1;
    localparam logic [1:0] c_ALU_FUNCT = 2'd2;
    localparam logic [1:0] c_B_REGB    = 2'd0;
    localparam logic [1:0] c_B_ONE     = 2'd1;
    localparam logic [1:0] c_B_IMM     = 2'd2;
    localparam logic [1:0] c_PC_ALU    = 2'd0;
    localparam logic [1:0] c_PC_ALUOUT = 2'd1;
    localparam logic [1:0] c_PC_JUMP   = 2'd2;
    localparam logic [1:0] c_WB_ALU    = 2'd0;
    localparam logic [1:0] c_WB_MDR    = 2'd1;
    localparam logic [1:0] c_WB_IN     = 2'd2;
    localparam logic [1:0] c_WB_PC     = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [3:0]       w_op;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    assign w_op    = opcode[3:0];
    assign retired = r_retired;

    // ------------------------------------------------------------------
    // State register and retired counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= c_S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_FETCH: begin
                if (mem_ready) w_next = c_S_DECODE;
            end
            c_S_DECODE: begin
                case (w_op)
                    4'h0, 4'h1, 4'h2, 4'h3: w_next = c_S_EXEC_R;
                    c_OP_ADDI:              w_next = c_S_EXEC_I;
                    c_OP_LW, c_OP_SW:       w_next = c_S_MEM_ADDR;
                    c_OP_BEQ, c_OP_BNE:     w_next = c_S_BRANCH;
                    c_OP_JAL:               w_next = c_S_JUMP;
                    c_OP_IN:                w_next = c_S_IO_IN;
                    c_OP_OUT:               w_next = c_S_IO_OUT;
                    c_OP_HALT:              w_next = c_S_HALT;
                    default:                w_next = c_S_FETCH;
                endcase
            end
            c_S_EXEC_R, c_S_EXEC_I: w_next = c_S_ALU_WB;
            c_S_MEM_ADDR: begin
                // Opcode is still held in IR, so it selects the memory direction.
                w_next = (w_op == c_OP_LW) ? c_S_MEM_RD : c_S_MEM_WR;
            end
            c_S_MEM_RD: begin
                if (mem_ready) w_next = c_S_MEM_WB;
            end
            c_S_MEM_WR: begin
                if (mem_ready) w_next = c_S_FETCH;
            end
            c_S_ALU_WB, c_S_MEM_WB, c_S_BRANCH,
            c_S_JUMP, c_S_IO_IN, c_S_IO_OUT: w_next = c_S_FETCH;
            c_S_HALT:  w_next = c_S_HALT;
            default:   w_next = c_S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Reset forces every output low combinationally so an
    // abandoned instruction issues no strobe in the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write  = 1'b0;
        pc_src    = c_PC_ALU;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = c_B_REGB;
        alu_op    = c_ALU_ADD;
        reg_write = 1'b0;
        wb_sel    = c_WB_ALU;
        out_write = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        w_retire  = 1'b0;
        if (!rst) begin
            case (r_state)
                c_S_FETCH: begin
                    mem_read = 1'b1;
                    // PC+1 and IR load only commit on the cycle data returns.
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = c_PC_ALU;
                        alu_src_b = c_B_ONE;
                    end
                end
                c_S_DECODE: begin
                    // Branch target precomputed into ALUOut.
                    alu_src_b = c_B_IMM;
                    illegal   = (w_op == 4'hC) || (w_op == 4'hD) || (w_op == 4'hE);
                    w_retire  = (w_op == c_OP_HALT);
                end
                c_S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = c_ALU_FUNCT;
                end
                c_S_EXEC_I, c_S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = c_B_IMM;
                end
                c_S_ALU_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = c_WB_ALU;
                    w_retire  = 1'b1;
                end
                c_S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                c_S_MEM_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = c_WB_MDR;
                    w_retire  = 1'b1;
                end
                c_S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    w_retire  = mem_ready;
                end
                c_S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = c_ALU_SUB;
                    pc_src    = c_PC_ALUOUT;
                    pc_write  = (w_op == c_OP_BNE) ? ~zero : zero;
                    w_retire  = 1'b1;
                end
                c_S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_src    = c_PC_JUMP;
                    reg_write = 1'b1;
                    wb_sel    = c_WB_PC;
                    w_retire  = 1'b1;
                end
                c_S_IO_IN: begin
                    reg_write = 1'b1;
                    wb_sel    = c_WB_IN;
                    w_retire  = 1'b1;
                end
                c_S_IO_OUT: begin
                    out_write = 1'b1;
                    w_retire  = 1'b1;
                end
                c_S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Self-checking bench for mc_control_unit. Each instruction is
//            expanded into its expected per-cycle control-word sequence and
//            retired count, then replayed against the DUT.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, iord, mem_read, mem_write, alu_src_a;
    logic        reg_write, out_write, halted, illegal;
    logic [1:0]  pc_src, alu_src_b, alu_op, wb_sel;
    logic [15:0] retired;
    logic [17:0] w_obs;

    int checks = 0;
    int errors = 0;

    mc_control_unit #(.OP_W(4), .CNT_W(16)) dut (
        .clock(clock), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .out_write(out_write), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    assign w_obs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_src_a,
                    alu_src_b, alu_op, reg_write, wb_sel, out_write, halted, illegal};

    typedef struct {
        logic        rdy;
        logic [17:0] exp;
        logic [15:0] ret;
    } cyc_t;

    cyc_t        q[$];
    logic [15:0] m_cnt = 16'h0;

    function automatic logic [17:0] vec(input logic pcw, input logic [1:0] pcs,
                                        input logic irw, input logic io, input logic mr,
                                        input logic mw, input logic a, input logic [1:0] b,
                                        input logic [1:0] op, input logic rw,
                                        input logic [1:0] wb, input logic ow,
                                        input logic h, input logic il);
        return {pcw, pcs, irw, io, mr, mw, a, b, op, rw, wb, ow, h, il};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic [17:0] exp);
        cyc_t c;
        c.rdy = rdy;
        c.exp = exp;
        c.ret = m_cnt;
        q.push_back(c);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from the ISA timing rules.
    task automatic build(input logic [3:0] op, input logic z, input int wf, input int wm,
                         input int nhalt);
        logic il;
        q.delete();
        for (int i = 0; i < wf; i++) push(1'b0, vec(0,0,0,0,1,0,0,0,0,0,0,0,0,0));
        push(1'b1, vec(1,0,1,0,1,0,0,1,0,0,0,0,0,0));
        il = (op >= 4'hC) && (op <= 4'hE);
        push(rnd(), vec(0,0,0,0,0,0,0,2,0,0,0,0,0,il));
        if (op <= 4'h3) begin
            push(rnd(), vec(0,0,0,0,0,0,1,0,2,0,0,0,0,0));
            push(rnd(), vec(0,0,0,0,0,0,0,0,0,1,0,0,0,0));
            m_cnt++;
        end else if (op == 4'h4) begin
            push(rnd(), vec(0,0,0,0,0,0,1,2,0,0,0,0,0,0));
            push(rnd(), vec(0,0,0,0,0,0,0,0,0,1,0,0,0,0));
            m_cnt++;
        end else if (op == 4'h5) begin
            push(rnd(), vec(0,0,0,0,0,0,1,2,0,0,0,0,0,0));
            for (int i = 0; i < wm; i++) push(1'b0, vec(0,0,0,1,1,0,0,0,0,0,0,0,0,0));
            push(1'b1, vec(0,0,0,1,1,0,0,0,0,0,0,0,0,0));
            push(rnd(), vec(0,0,0,0,0,0,0,0,0,1,1,0,0,0));
            m_cnt++;
        end else if (op == 4'h6) begin
            push(rnd(), vec(0,0,0,0,0,0,1,2,0,0,0,0,0,0));
            for (int i = 0; i < wm; i++) push(1'b0, vec(0,0,0,1,0,1,0,0,0,0,0,0,0,0));
            push(1'b1, vec(0,0,0,1,0,1,0,0,0,0,0,0,0,0));
            m_cnt++;
        end else if (op == 4'h7 || op == 4'h8) begin
            push(rnd(), vec((op == 4'h7) ? z : ~z,1,0,0,0,0,1,0,1,0,0,0,0,0));
            m_cnt++;
        end else if (op == 4'h9) begin
            push(rnd(), vec(1,2,0,0,0,0,0,0,0,1,3,0,0,0));
            m_cnt++;
        end else if (op == 4'hA) begin
            push(rnd(), vec(0,0,0,0,0,0,0,0,0,1,2,0,0,0));
            m_cnt++;
        end else if (op == 4'hB) begin
            push(rnd(), vec(0,0,0,0,0,0,0,0,0,0,0,1,0,0));
            m_cnt++;
        end else if (op == 4'hF) begin
            m_cnt++;
            for (int i = 0; i < nhalt; i++) push(rnd(), vec(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
        end
    endtask

    // Replays the first n expected cycles against the DUT.
    task automatic exec(input logic [3:0] op, input logic z, input int n, input string tag);
        for (int i = 0; i < n && i < q.size(); i++) begin
            @(negedge clock);
            if (i == 0) begin
                opcode = op;
                zero   = z;
            end
            mem_ready = q[i].rdy;
            #1;
            checks++;
            if (w_obs !== q[i].exp) begin
                errors++;
                $display("FAIL %s cycle %0d controls got %h exp %h", tag, i, w_obs, q[i].exp);
            end
            checks++;
            if (retired !== q[i].ret) begin
                errors++;
                $display("FAIL %s cycle %0d retired got %h exp %h", tag, i, retired, q[i].ret);
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int wf, input int wm,
                             input string tag);
        build(op, z, wf, wm, 20);
        exec(op, z, q.size(), tag);
    endtask

    // Two reset cycles, then release into a FETCH wait cycle.
    task automatic apply_reset(input string tag);
        @(negedge clock);
        rst = 1'b1;
        mem_ready = rnd();
        #1;
        checks++;
        if (w_obs !== 18'h0) begin
            errors++;
            $display("FAIL %s in-reset controls got %h exp %h", tag, w_obs, 18'h0);
        end
        @(negedge clock);
        #1;
        checks++;
        if (retired !== 16'h0) begin
            errors++;
            $display("FAIL %s retired got %h exp %h", tag, retired, 16'h0);
        end
        rst = 1'b0;
        mem_ready = 1'b0;
        m_cnt = 16'h0;
        #1;
        checks++;
        if (w_obs !== vec(0,0,0,0,1,0,0,0,0,0,0,0,0,0)) begin
            errors++;
            $display("FAIL %s post-reset fetch got %h exp %h", tag, w_obs,
                     vec(0,0,0,0,1,0,0,0,0,0,0,0,0,0));
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_add();
        run_instr(4'h0, 1'b0, 0, 0, "add");
    endtask

    task automatic test_lw_wait();
        run_instr(4'h5, 1'b0, 0, 3, "lw_wait");
        run_instr(4'h6, 1'b1, 2, 1, "sw_wait");
    endtask

    task automatic test_branch();
        run_instr(4'h7, 1'b1, 0, 0, "beq_z1");
        run_instr(4'h8, 1'b1, 0, 0, "bne_z1");
        run_instr(4'h7, 1'b0, 1, 0, "beq_z0");
        run_instr(4'h8, 1'b0, 0, 0, "bne_z0");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op, rnd(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      "random");
        end
    endtask

    task automatic test_reset_mid_write();
        build(4'h6, 1'b0, 0, 5, 0);
        exec(4'h6, 1'b0, 5, "sw_pre_reset");
        apply_reset("reset_mid_write");
        run_instr(4'hB, 1'b0, 0, 0, "out_after_reset");
    endtask

    task automatic test_wrap();
        @(negedge clock);
        mem_ready = 1'b0;
        force dut.r_retired = 16'hFFFF;
        #1;
        release dut.r_retired;
        m_cnt = 16'hFFFF;
        run_instr(4'hB, 1'b0, 0, 0, "wrap_out");
        run_instr(4'hB, 1'b0, 0, 0, "after_wrap");
    endtask

    task automatic test_illegal_halt();
        run_instr(4'hC, 1'b0, 0, 0, "illegal_c");
        run_instr(4'hE, 1'b0, 1, 0, "illegal_e");
        run_instr(4'hF, 1'b0, 0, 0, "halt");
        apply_reset("reset_from_halt");
        run_instr(4'h9, 1'b0, 0, 0, "jal_after_halt");
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_random();
        test_reset_mid_write();
        test_wrap();
        test_illegal_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
